param_sync_fifo: RTL and testbench
==================================

PARAM_SYNC_FIFO -- requirements
Module: param_sync_fifo

Interface
REQ-001 Parameters SHALL be, one per line:
- DATA_W, 8, data width in bits.
- DEPTH, 8, number of entries; power of two, >= 2.
- AF_THRESH, DEPTH-2, almost_full threshold; 1..DEPTH.
- AE_THRESH, 2, almost_empty threshold; 0..DEPTH-1.
- FWFT, 0, read mode: 0 = registered read, 1 = first-word-fall-through.

REQ-002 Ports SHALL be, one per line:
- clk  in  1  single clock; all logic on posedge.
- rst  in  1  reset; synchronous, active-high.
- flush  in  1  synchronous clear of FIFO contents.
- err_clr  in  1  clears sticky error flags.
- wr  in  1  write request.
- Wdata  in  DATA_W  write data.
- rd  in  1  read request (FWFT=1: pop of head entry).
- Rdata  out  DATA_W  read data.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count >= AF_THRESH.
- almost_empty  out  1  count <= AE_THRESH.
- count  out  $clog2(DEPTH)+1  current occupancy.
- overflow  out  1  sticky: write attempted while full.
- underflow  out  1  sticky: read attempted while empty.

Function
REQ-003 Write accept = wr && !full; at the accepting edge, Wdata goes to mem[wptr] and wptr increments.
REQ-004 Read accept = rd && !empty; at the accepting edge, rptr increments.
REQ-005 wptr and rptr SHALL be $clog2(DEPTH) bits and wrap modulo DEPTH with no extra logic; count is tracked as a separate register.
REQ-006 count: +1 on write-only accept, -1 on read-only accept, unchanged when both accept or neither accepts; never exceeds DEPTH and never goes below 0.
REQ-007 full, empty, almost_full and almost_empty SHALL decode combinationally from the registered count, so they reflect an accept one cycle after its edge.
REQ-008 Simultaneous wr and rd when full: read accepted, write rejected, overflow set; count becomes DEPTH-1.
REQ-009 Simultaneous wr and rd when empty: write accepted, read rejected, underflow set; count becomes 1.
REQ-010 FWFT=0: Rdata is a register loaded with mem[rptr] at a read-accept edge, valid the following cycle; otherwise it holds its value.
REQ-011 FWFT=1: Rdata = mem[rptr] whenever !empty; a written word appears on Rdata the cycle after it is written into an empty FIFO; rd advances to the next word; Rdata is don't-care while empty.
REQ-012 overflow is set at any edge with wr && full; underflow is set at any edge with rd && empty; both hold until err_clr or rst.
REQ-013 If err_clr and a new error coincide, the flag SHALL end set (set wins).
REQ-014 flush SHALL set wptr, rptr and count to 0.
- wr and rd in the flush cycle are ignored.
- overflow, underflow and Rdata (FWFT=0) are unchanged.
REQ-015 Priority SHALL be rst > flush > normal operation.
REQ-016 Memory contents SHALL NOT be reset; only pointers, count, flags and Rdata are reset.

Reset
REQ-017 At an edge with rst=1, all operations SHALL be abandoned, including rst asserted mid-burst.
REQ-018 On that edge: wptr=0, rptr=0, count=0, Rdata=0, overflow=0, underflow=0.
REQ-019 Resulting outputs: empty=1, full=0, almost_empty=1, almost_full=0.
REQ-020 The first write after rst deasserts SHALL be accepted.

Verification (DEPTH=8, DATA_W=8, AF_THRESH=6, AE_THRESH=2, FWFT=0 unless stated)
REQ-021 Fill: 8 writes 0x10..0x17 -> almost_full=1 after the 6th, full=1 and count=8 after the 8th; a 9th write -> overflow=1, count=8.
REQ-022 Drain: 8 reads -> Rdata 0x10..0x17 in order, each one cycle after its rd; empty=1 after the 8th; a 9th rd -> underflow=1, Rdata holds 0x17.
REQ-023 Wrap: write 5, read 5, write 8 (0x20..0x27), read 8 -> Rdata 0x20..0x27 in order, full reached with wptr wrapped.
REQ-024 Simultaneous wr+rd at three occupancies -> count 4 stays 4; count 8 becomes 7 with overflow=1; count 0 becomes 1 with underflow=1.
REQ-025 flush at count 5 with wr=1 and overflow=1 -> next cycle count=0, empty=1, overflow=1; err_clr -> overflow=0.
REQ-026 FWFT=1: write 0xA5 into empty -> next cycle empty=0, Rdata=0xA5 with no rd; rst during a 4-word burst -> count=0, empty=1 next cycle.

Source files
------------

// File: rtl/param_sync_fifo.sv
// -----------------------------------------------------------------------------
// param_sync_fifo
//
// Single-clock FIFO with configurable width/depth, almost-full/almost-empty
// thresholds, sticky overflow/underflow flags, synchronous flush and a choice
// of registered-read or first-word-fall-through output.
//
// Parameters
//   DATA_W     data width in bits
//   DEPTH      number of entries (power of two, >= 2)
//   AF_THRESH  almost_full asserted when count >= AF_THRESH (1..DEPTH)
//   AE_THRESH  almost_empty asserted when count <= AE_THRESH (0..DEPTH-1)
//   FWFT       0: Rdata is a register loaded on each read accept
//              1: Rdata shows the head entry whenever the FIFO is not empty
//
// Ports
//   clk           clock, all logic on the rising edge
//   rst           synchronous active-high reset
//   flush         synchronous clear of pointers and count
//   err_clr       clears the sticky overflow/underflow flags
//   wr, Wdata     write request and data
//   rd            read request (FWFT=1: pop of the head entry)
//   Rdata         read data
//   full, empty   count == DEPTH / count == 0
//   almost_full   count >= AF_THRESH
//   almost_empty  count <= AE_THRESH
//   count         current occupancy
//   overflow      sticky: write attempted while full
//   underflow     sticky: read attempted while empty
// -----------------------------------------------------------------------------
module param_sync_fifo #(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 8,
    parameter int AF_THRESH = DEPTH - 2,
    parameter int AE_THRESH = 2,
    parameter int FWFT      = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     err_clr,
    input  logic                     wr,
    input  logic [DATA_W-1:0]        Wdata,
    input  logic                     rd,
    output logic [DATA_W-1:0]        Rdata,
    output logic                     full,
    output logic                     empty,
    output logic                     almost_full,
    output logic                     almost_empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    // Storage: no reset so it maps onto RAM primitives.
    logic [DATA_W-1:0] mem [DEPTH];

    logic [AW-1:0] wptr_reg, wptr_next;
    logic [AW-1:0] rptr_reg, rptr_next;
    logic [CW-1:0] count_reg, count_next;
    logic          overflow_reg, overflow_next;
    logic          underflow_reg, underflow_next;

    logic          wr_accept;
    logic          rd_accept;
    logic          mem_we;

    // Status decodes straight from the registered count.
    assign full         = (count_reg == CW'(DEPTH));
    assign empty        = (count_reg == '0);
    assign almost_full  = (count_reg >= CW'(AF_THRESH));
    assign almost_empty = (count_reg <= CW'(AE_THRESH));

    assign count     = count_reg;
    assign overflow  = overflow_reg;
    assign underflow = underflow_reg;

    // Accepts are gated by the registered flags; this is what makes a
    // simultaneous wr+rd at full pop only, and at empty push only.
    assign wr_accept = wr && !full;
    assign rd_accept = rd && !empty;

    // Flush discards any request in the same cycle, so it also blocks writes.
    assign mem_we = wr_accept && !flush && !rst;

    // -------------------------------------------------------------------------
    // Next-state logic for pointers, occupancy and error flags
    // -------------------------------------------------------------------------
    always_comb begin
        wptr_next      = wptr_reg;
        rptr_next      = rptr_reg;
        count_next     = count_reg;
        overflow_next  = overflow_reg;
        underflow_next = underflow_reg;

        if (flush) begin
            // Contents are discarded; error flags are deliberately left alone
            // so software can still see what happened before the flush.
            wptr_next  = '0;
            rptr_next  = '0;
            count_next = '0;
        end else begin
            // Pointers are exactly AW bits wide, so +1 wraps modulo DEPTH.
            if (wr_accept) begin
                wptr_next = wptr_reg + 1'b1;
            end
            if (rd_accept) begin
                rptr_next = rptr_reg + 1'b1;
            end

            unique case ({wr_accept, rd_accept})
                2'b10:   count_next = count_reg + 1'b1;
                2'b01:   count_next = count_reg - 1'b1;
                default: count_next = count_reg;
            endcase

            // Clear first, then set, so a coincident new error wins.
            if (err_clr) begin
                overflow_next  = 1'b0;
                underflow_next = 1'b0;
            end
            if (wr && full) begin
                overflow_next = 1'b1;
            end
            if (rd && empty) begin
                underflow_next = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_reg      <= '0;
            rptr_reg      <= '0;
            count_reg     <= '0;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            wptr_reg      <= wptr_next;
            rptr_reg      <= rptr_next;
            count_reg     <= count_next;
            overflow_reg  <= overflow_next;
            underflow_reg <= underflow_next;
        end
    end

    // Memory write port.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[wptr_reg] <= Wdata;
        end
    end

    // -------------------------------------------------------------------------
    // Read port
    // -------------------------------------------------------------------------
    generate
        if (FWFT == 0) begin : g_registered_read
            logic [DATA_W-1:0] rdata_reg;

            // Loaded only on a read accept; holds otherwise (including flush).
            always_ff @(posedge clk) begin
                if (rst) begin
                    rdata_reg <= '0;
                end else if (!flush && rd_accept) begin
                    rdata_reg <= mem[rptr_reg];
                end
            end

            assign Rdata = rdata_reg;
        end else begin : g_fwft_read
            // Head entry is presented directly; meaningless while empty.
            assign Rdata = mem[rptr_reg];
        end
    endgenerate

endmodule

// File: tb/tb_param_sync_fifo.sv
`timescale 1ns/1ps
module tb_param_sync_fifo;

    logic       clk = 1'b0;
    logic       rst;

    // Registered-read instance
    logic       flush, err_clr, wr, rd;
    logic [7:0] wdata, rdata;
    logic       full, empty, afull, aempty, ovf, unf;
    logic [3:0] count;

    // FWFT instance
    logic       flush_f, err_clr_f, wr_f, rd_f;
    logic [7:0] wdata_f, rdata_f;
    logic       full_f, empty_f, afull_f, aempty_f, ovf_f, unf_f;
    logic [3:0] count_f;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    param_sync_fifo #(.DATA_W(8), .DEPTH(8), .AF_THRESH(6), .AE_THRESH(2), .FWFT(0)) dut (
        .clk(clk), .rst(rst), .flush(flush), .err_clr(err_clr),
        .wr(wr), .Wdata(wdata), .rd(rd), .Rdata(rdata),
        .full(full), .empty(empty), .almost_full(afull), .almost_empty(aempty),
        .count(count), .overflow(ovf), .underflow(unf)
    );

    param_sync_fifo #(.DATA_W(8), .DEPTH(8), .AF_THRESH(6), .AE_THRESH(2), .FWFT(1)) dut_f (
        .clk(clk), .rst(rst), .flush(flush_f), .err_clr(err_clr_f),
        .wr(wr_f), .Wdata(wdata_f), .rd(rd_f), .Rdata(rdata_f),
        .full(full_f), .empty(empty_f), .almost_full(afull_f), .almost_empty(aempty_f),
        .count(count_f), .overflow(ovf_f), .underflow(unf_f)
    );

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) begin
            $display("check %-14s ok  observed=%0h", tag, obs);
        end else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; flush = 0; err_clr = 0; wr = 0; rd = 0; wdata = 8'h00;
        flush_f = 0; err_clr_f = 0; wr_f = 0; rd_f = 0; wdata_f = 8'h00;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_aempty", aempty, 1);
        check("rst_afull", afull, 0);
        check("rst_count", count, 0);
        check("rst_rdata", rdata, 8'h00);
        check("rst_ovf", ovf, 0);
        check("rst_unf", unf, 0);

        // Fill 0x10..0x17
        for (int i = 0; i < 8; i++) begin
            wr = 1; wdata = 8'h10 + 8'(i);
            tick();
            check("fill_count", count, i + 1);
            check("fill_afull", afull, (i + 1 >= 6) ? 1 : 0);
            check("fill_aempty", aempty, (i + 1 <= 2) ? 1 : 0);
            check("fill_full", full, (i == 7) ? 1 : 0);
        end
        wdata = 8'h99;
        tick();
        wr = 0;
        check("ovf_set", ovf, 1);
        check("ovf_count", count, 8);

        // Drain
        for (int i = 0; i < 8; i++) begin
            rd = 1;
            tick();
            check("drain_data", rdata, 8'h10 + i);
            check("drain_count", count, 7 - i);
        end
        check("drain_empty", empty, 1);
        tick();
        rd = 0;
        check("unf_set", unf, 1);
        check("unf_hold", rdata, 8'h17);
        err_clr = 1;
        tick();
        err_clr = 0;
        check("clr_ovf", ovf, 0);
        check("clr_unf", unf, 0);

        // Wrap: write 5, read 5, then a full 8-word pass across the wrap
        for (int i = 0; i < 5; i++) begin
            wr = 1; wdata = 8'h30 + 8'(i); tick();
        end
        wr = 0;
        for (int i = 0; i < 5; i++) begin
            rd = 1; tick();
            check("wrap_pre", rdata, 8'h30 + i);
        end
        rd = 0;
        for (int i = 0; i < 8; i++) begin
            wr = 1; wdata = 8'h20 + 8'(i); tick();
        end
        wr = 0;
        check("wrap_full", full, 1);
        for (int i = 0; i < 8; i++) begin
            rd = 1; tick();
            check("wrap_data", rdata, 8'h20 + i);
        end
        rd = 0;
        check("wrap_empty", empty, 1);

        // Simultaneous wr+rd at count 4
        for (int i = 0; i < 4; i++) begin
            wr = 1; wdata = 8'h40 + 8'(i); tick();
        end
        wr = 1; rd = 1; wdata = 8'h44;
        tick();
        wr = 0; rd = 0;
        check("sim4_count", count, 4);
        check("sim4_data", rdata, 8'h40);
        // Now holds 41..44; top up to full with 45..48
        for (int i = 0; i < 4; i++) begin
            wr = 1; wdata = 8'h45 + 8'(i); tick();
        end
        wr = 0;
        check("sim8_pre", full, 1);
        wr = 1; rd = 1; wdata = 8'hEE;
        tick();
        wr = 0; rd = 0;
        check("sim8_count", count, 7);
        check("sim8_ovf", ovf, 1);
        check("sim8_data", rdata, 8'h41);
        for (int i = 0; i < 7; i++) begin
            rd = 1; tick();
            check("sim8_drain", rdata, 8'h42 + i);
        end
        rd = 0;
        check("sim0_pre", empty, 1);
        wr = 1; rd = 1; wdata = 8'h50;
        tick();
        wr = 0; rd = 0;
        check("sim0_count", count, 1);
        check("sim0_unf", unf, 1);
        check("sim0_data", rdata, 8'h48);
        rd = 1; tick(); rd = 0;
        check("sim0_read", rdata, 8'h50);

        // err_clr coinciding with a new underflow: set wins; overflow clears
        err_clr = 1; rd = 1;
        tick();
        err_clr = 0; rd = 0;
        check("setwin_unf", unf, 1);
        check("setwin_ovf", ovf, 0);
        err_clr = 1; tick(); err_clr = 0;
        check("clr2_unf", unf, 0);

        // Flush at count 5 with overflow pending and wr high
        for (int i = 0; i < 9; i++) begin
            wr = 1; wdata = 8'h60 + 8'(i); tick();
        end
        wr = 0;
        for (int i = 0; i < 3; i++) begin
            rd = 1; tick();
        end
        rd = 0;
        check("fl_pre_count", count, 5);
        check("fl_pre_ovf", ovf, 1);
        check("fl_pre_data", rdata, 8'h62);
        flush = 1; wr = 1; wdata = 8'h77;
        tick();
        flush = 0; wr = 0;
        check("fl_count", count, 0);
        check("fl_empty", empty, 1);
        check("fl_ovf", ovf, 1);
        check("fl_data", rdata, 8'h62);
        err_clr = 1; tick(); err_clr = 0;
        check("fl_clr", ovf, 0);
        wr = 1; wdata = 8'h81; tick(); wr = 0;
        rd = 1; tick(); rd = 0;
        check("fl_after", rdata, 8'h81);

        // FWFT: written word visible without a read
        wr_f = 1; wdata_f = 8'hA5;
        tick();
        wr_f = 0;
        check("fw_empty", empty_f, 0);
        check("fw_data", rdata_f, 8'hA5);
        wr_f = 1; wdata_f = 8'hB6;
        tick();
        wr_f = 0;
        check("fw_hold", rdata_f, 8'hA5);
        rd_f = 1;
        tick();
        check("fw_pop", rdata_f, 8'hB6);
        check("fw_cnt1", count_f, 1);
        tick();
        rd_f = 0;
        check("fw_empty2", empty_f, 1);

        // Reset in the middle of a 4-word burst (both instances)
        for (int i = 0; i < 2; i++) begin
            wr = 1; wdata = 8'h90 + 8'(i);
            wr_f = 1; wdata_f = 8'hC0 + 8'(i);
            tick();
        end
        rst = 1; wdata = 8'h92; wdata_f = 8'hC2;
        tick();
        rst = 0; wr = 0; wr_f = 0;
        check("fw_rst_count", count_f, 0);
        check("fw_rst_empty", empty_f, 1);
        check("mb_rst_count", count, 0);
        check("mb_rst_data", rdata, 8'h00);

        // First write after reset is accepted
        wr = 1; wdata = 8'hD1; wr_f = 1; wdata_f = 8'hC3;
        tick();
        wr = 0; wr_f = 0;
        check("post_rst_cnt", count, 1);
        check("fw_post_rst", rdata_f, 8'hC3);
        rd = 1; tick(); rd = 0;
        check("post_rst_rd", rdata, 8'hD1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
